// File: rtl/full_idct_pkg.sv
// Shared widths, cosine constants and FSM state type for the 8x8 IDCT.
// The table is scaled by 2^12 (FRAC) and rounded to the nearest integer.
package full_idct_pkg;

  localparam int IN_W_DEF  = 12;
  localparam int MID_W_DEF = 16;
  localparam int FRAC_DEF  = 12;
  localparam int COEF_W    = 14;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // DC weight (C0/2) and (1/2)*cos(k*pi/16) for k = 0..8
  localparam logic signed [COEF_W-1:0] C0_K = 14'sd1448;
  localparam logic signed [COEF_W-1:0] COS_K [9] = '{
    14'sd2048, 14'sd2009, 14'sd1892, 14'sd1703, 14'sd1448,
    14'sd1138, 14'sd784,  14'sd400,  14'sd0
  };

  // Weight of input lane u on output lane x, folded onto the first quadrant.
  function automatic logic signed [COEF_W-1:0] idct_coef(input int u, input int x);
    int m;
    if (u == 0) return C0_K;
    m = ((2 * x + 1) * u) % 32;
    if (m > 16) m = 32 - m;
    if (m > 8) return -COS_K[4'(16 - m)];
    return COS_K[4'(m)];
  endfunction

endpackage

// File: rtl/idct_1d_8pt.sv
// Combinational 8-point 1D IDCT; returns full-precision sums (scaled by 2^FRAC)
// so the caller chooses its own rounding and saturation.
module idct_1d_8pt
  import full_idct_pkg::*;
#(
  parameter int IW = 12,
  parameter int SW = IW + COEF_W + 3
) (
  input  logic [8*IW-1:0] x_i,
  output logic [8*SW-1:0] y_o
);

  always_comb begin
    logic signed [SW-1:0] acc;
    y_o = '0;
    for (int x = 0; x < 8; x++) begin
      acc = '0;
      for (int u = 0; u < 8; u++) begin
        acc = acc + SW'(signed'(x_i[u*IW +: IW])) * SW'(idct_coef(u, x));
      end
      y_o[x*SW +: SW] = acc;
    end
  end

endmodule

// File: rtl/full_idct.sv
// 8x8 2D IDCT: row pass into a transpose buffer, then column pass to pixels.
// Optional FULL_IDCT_OUT_REG_EN adds one output register stage after clamping.
module full_idct
  import full_idct_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int MID_W = MID_W_DEF,
  parameter int FRAC  = FRAC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [8*IN_W-1:0] data_in,
  output logic              out_valid,
  output logic [63:0]       data_out,
  output logic              out_last
);

  localparam int RSW = IN_W + COEF_W + 3;
  localparam int CSW = MID_W + COEF_W + 3;
  localparam logic signed [RSW-1:0] MID_MAX = RSW'((2 ** (MID_W - 1)) - 1);
  localparam logic signed [RSW-1:0] MID_MIN = -MID_MAX - RSW'(1);

  function automatic logic signed [MID_W-1:0] round_sat_mid(input logic signed [RSW-1:0] s);
    logic signed [RSW-1:0] t;
    t = (s + (RSW'(1) <<< (FRAC - 1))) >>> FRAC;
    if (t > MID_MAX) return MID_W'(MID_MAX);
    if (t < MID_MIN) return MID_W'(MID_MIN);
    return MID_W'(t);
  endfunction

  function automatic logic [7:0] round_clamp_pix(input logic signed [CSW-1:0] s);
    logic signed [CSW-1:0] t;
    t = (s + (CSW'(128) <<< FRAC) + (CSW'(1) <<< (FRAC - 1))) >>> FRAC;
    if (t < 0) return 8'd0;
    if (t > CSW'(255)) return 8'd255;
    return t[7:0];
  endfunction

  state_e                  state_q;
  logic [2:0]              r_q, c_q;
  logic                    in_ready_q, out_valid_q, out_last_q;
  logic [63:0]             data_out_q;
  logic signed [MID_W-1:0] tbuf_q [8][8];
  logic [8*RSW-1:0]        row_sum;
  logic [8*MID_W-1:0]      col_in;
  logic [8*CSW-1:0]        col_sum;
  logic [63:0]             pix_d;
  logic                    xfer;

  assign xfer = in_valid && in_ready_q;

  // Stage: row pass, result lands in transpose row r
  idct_1d_8pt #(.IW(IN_W), .SW(RSW)) u_row (.x_i(data_in), .y_o(row_sum));

  always_ff @(posedge clk) begin
    if (xfer) begin
      for (int x = 0; x < 8; x++) begin
        tbuf_q[r_q][x] <= round_sat_mid(row_sum[x*RSW +: RSW]);
      end
    end
  end

  // Stage: column pass on transpose column c
  always_comb begin
    col_in = '0;
    for (int u = 0; u < 8; u++) begin
      col_in[u*MID_W +: MID_W] = tbuf_q[u][c_q];
    end
  end

  idct_1d_8pt #(.IW(MID_W), .SW(CSW)) u_col (.x_i(col_in), .y_o(col_sum));

  always_comb begin
    pix_d = '0;
    for (int x = 0; x < 8; x++) begin
      pix_d[x*8 +: 8] = round_clamp_pix(col_sum[x*CSW +: CSW]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FILL;
      r_q         <= 3'd0;
      c_q         <= 3'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      data_out_q  <= '0;
    end else begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      case (state_q)
        FILL: begin
          if (xfer) begin
            r_q <= r_q + 3'd1;
            if (r_q == 3'd7) begin
              state_q    <= DRAIN;
              in_ready_q <= 1'b0;
            end
          end
        end
        DRAIN: begin
          data_out_q  <= pix_d;
          out_valid_q <= 1'b1;
          out_last_q  <= (c_q == 3'd7);
          c_q         <= c_q + 3'd1;
          if (c_q == 3'd7) begin
            state_q    <= FILL;
            in_ready_q <= 1'b1;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign in_ready = in_ready_q;

`ifdef FULL_IDCT_OUT_REG_EN
  logic        out_valid_p2, out_last_p2;
  logic [63:0] data_out_p2;

  // Stage: extra output register, valid and last delayed with the data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_p2 <= 1'b0;
      out_last_p2  <= 1'b0;
      data_out_p2  <= '0;
    end else begin
      out_valid_p2 <= out_valid_q;
      out_last_p2  <= out_last_q;
      if (out_valid_q) data_out_p2 <= data_out_q;
    end
  end

  assign out_valid = out_valid_p2;
  assign out_last  = out_last_p2;
  assign data_out  = data_out_p2;
`else
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign data_out  = data_out_q;
`endif

endmodule

// File: tb/tb_full_idct.sv
// Bench for full_idct: double-precision 2D IDCT model, per-beat scoreboard,
// latency and ready checks. Honours FULL_IDCT_OUT_REG_EN for the latency.
module tb_full_idct;

  localparam int IN_W = 12;
`ifdef FULL_IDCT_OUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic [8*IN_W-1:0] data_in = '0;
  logic              in_ready, out_valid, out_last;
  logic [63:0]       data_out;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int blk [8][8];
  int mdl [8][8];

  logic [63:0] exp_data_q [$];
  bit          exp_last_q [$];
  bit          exp_first_q [$];
  int          exp_tol_q [$];
  int          lat_q [$];

  logic [63:0] last_seen = '0;
  logic [63:0] m_e;
  int          m_tol, m_d, m_xf;
  bit          m_l, m_f, m_ok;

  full_idct dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .out_valid(out_valid), .data_out(data_out), .out_last(out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Ideal 2D IDCT: row index r is vertical frequency (acts on x), lane u horizontal (acts on c)
  function automatic void model_block();
    real pi, s, cr, cu;
    int v;
    pi = 3.14159265358979323846;
    for (int x = 0; x < 8; x++) begin
      for (int c = 0; c < 8; c++) begin
        s = 0.0;
        for (int r = 0; r < 8; r++) begin
          for (int u = 0; u < 8; u++) begin
            cr = (r == 0) ? $sqrt(0.5) : 1.0;
            cu = (u == 0) ? $sqrt(0.5) : 1.0;
            s = s + cr * cu / 4.0 * blk[r][u]
                  * $cos((2 * x + 1) * r * pi / 16.0) * $cos((2 * c + 1) * u * pi / 16.0);
          end
        end
        v = $rtoi($floor(s + 128.0 + 0.5));
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        mdl[x][c] = v;
      end
    end
  endfunction

  function automatic void set_dc(input int dc);
    for (int r = 0; r < 8; r++) for (int u = 0; u < 8; u++) blk[r][u] = 0;
    blk[0][0] = dc;
  endfunction

  // Energy kept in the top four rows and moderate so the fixed-point path stays within 1 LSB
  function automatic void rand_block();
    for (int r = 0; r < 8; r++)
      for (int u = 0; u < 8; u++)
        blk[r][u] = (r < 4) ? int'($urandom_range(120, 0)) - 60 : 0;
    blk[0][0] = int'($urandom_range(600, 0)) - 300;
  endfunction

  function automatic logic [8*IN_W-1:0] pack_row(input int r);
    logic [8*IN_W-1:0] v;
    for (int u = 0; u < 8; u++) v[u*IN_W +: IN_W] = IN_W'(blk[r][u]);
    return v;
  endfunction

  function automatic void push_expect(input int tol);
    logic [63:0] d;
    for (int c = 0; c < 8; c++) begin
      for (int x = 0; x < 8; x++) d[x*8 +: 8] = 8'(mdl[x][c]);
      exp_data_q.push_back(d);
      exp_last_q.push_back(c == 7);
      exp_first_q.push_back(c == 0);
      exp_tol_q.push_back(tol);
    end
  endfunction

  // Entered and left on a falling edge; xf is the cycle in which the row transfers
  task automatic send_row(input logic [8*IN_W-1:0] row, input bit hold, output int xf);
    int n;
    n = 0;
    in_valid = 1'b1;
    data_in  = row;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL row_accept_timeout: in_ready=%0b after %0d cycles want 1", in_ready, n);
    end
    xf = cyc;
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic send_block(input int gap_max, input bit hold, input int tol);
    int xf;
    for (int r = 0; r < 8; r++) begin
      if (r == 7) begin
        model_block();
        push_expect(tol);
      end
      send_row(pack_row(r), hold && (r == 7), xf);
      if (r == 7) lat_q.push_back(xf);
      if (gap_max > 0 && r < 7) repeat ($urandom_range(gap_max, 0)) @(negedge clk);
    end
    if (hold) begin
      for (int i = 0; i < 8; i++) begin
        chk("ready_low_in_drain", in_ready, 1'b0);
        data_in = {$urandom, $urandom, $urandom};
        @(negedge clk);
      end
      chk("ready_after_drain", in_ready, 1'b1);
      in_valid = 1'b0;
    end
  endtask

  // Scoreboard: every beat, latency of each block's first beat, and hold behaviour between beats
  always @(negedge clk) begin
    if (reset) begin
      last_seen = '0;
    end else if (out_valid) begin
      if (exp_data_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_beat: out_valid=1 data=%h want no beat", data_out);
      end else begin
        m_e   = exp_data_q.pop_front();
        m_l   = exp_last_q.pop_front();
        m_f   = exp_first_q.pop_front();
        m_tol = exp_tol_q.pop_front();
        m_ok  = 1'b1;
        for (int x = 0; x < 8; x++) begin
          m_d = int'(data_out[x*8 +: 8]) - int'(m_e[x*8 +: 8]);
          if (m_d > m_tol || m_d < -m_tol) m_ok = 1'b0;
        end
        checks++;
        if (!m_ok) begin
          errors++;
          $display("FAIL beat_data: got %h want %h (tol %0d)", data_out, m_e, m_tol);
        end
        chk("beat_last", out_last, m_l);
        if (m_f) begin
          checks++;
          if (lat_q.size() == 0) begin
            errors++;
            $display("FAIL first_beat_latency: no row-7 transfer recorded, want one");
          end else begin
            m_xf = lat_q.pop_front();
            if (cyc - m_xf != LAT) begin
              errors++;
              $display("FAIL first_beat_latency: got %0d cycles want %0d", cyc - m_xf, LAT);
            end
          end
        end
      end
      last_seen = data_out;
    end else begin
      chk("idle_hold_data", data_out, last_seen);
      chk("idle_last_low", out_last, 1'b0);
    end
  end

  initial begin
    int n;
    int xf;

    // Hand-computed values pinning the reference model
    set_dc(0);     model_block(); chk("model_zero", mdl[2][6], 128);
    set_dc(64);    model_block(); chk("model_dc64", mdl[3][5], 136);
    set_dc(-1024); model_block(); chk("model_dc_neg1024", mdl[7][0], 0);
    set_dc(2047);  model_block(); chk("model_dc2047", mdl[0][7], 255);
    set_dc(0); blk[1][0] = 16; model_block();
    chk("model_vert_top", mdl[0][0], 131);
    chk("model_vert_bottom", mdl[7][3], 125);

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_last", out_last, 1'b0);
    chk("reset_data_out", data_out, 64'h0);

    set_dc(0);     send_block(0, 1'b0, 0);
    set_dc(64);    send_block(3, 1'b0, 0);
    set_dc(-1024); send_block(0, 1'b0, 0);
    set_dc(2047);  send_block(2, 1'b0, 0);
    set_dc(-2048); send_block(0, 1'b0, 0);
    set_dc(0); blk[1][0] = 16; send_block(0, 1'b0, 1);
    rand_block();  send_block(4, 1'b0, 1);
    rand_block();  send_block(2, 1'b1, 1);

    // Partial block discarded by reset
    rand_block();
    for (int r = 0; r < 4; r++) send_row(pack_row(r), 1'b0, xf);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("midreset_in_ready", in_ready, 1'b1);
    chk("midreset_out_valid", out_valid, 1'b0);
    chk("midreset_data_out", data_out, 64'h0);
    repeat (12) @(negedge clk);
    chk("midreset_no_beats", out_valid, 1'b0);
    set_dc(64); send_block(0, 1'b0, 0);

    // Back-to-back random blocks
    for (int b = 0; b < 3; b++) begin
      rand_block();
      send_block(0, 1'b0, 1);
    end

    n = 0;
    while (exp_data_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_data_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d beats outstanding want 0", exp_data_q.size());
    end
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
